// File: rtl/pipelined_divider_pkg.sv
// Shared types and helpers for the pipelined divider.
// Contents:
//   stage_count()   number of iteration stages for a given width / bits-per-stage
//   DbzQuotient     all-ones quotient returned on divide-by-zero (slice to width)
//   side_flags_t    per-stage control sideband; the tag travels next to it as a
//                   separate tag_width vector so the struct itself stays width-free
package pipelined_divider_pkg;

    localparam int unsigned MaxWidth = 64;
    localparam logic [MaxWidth-1:0] DbzQuotient = '1;

    typedef struct packed {
        logic valid;
        logic signed_op;
        logic dividend_neg;
        logic divisor_neg;
        logic dbz;
        logic overflow;
    } side_flags_t;

    function automatic int unsigned stage_count(int unsigned width, int unsigned bits_per_stage);
        return width / bits_per_stage;
    endfunction

endpackage

// File: rtl/pipelined_divider_sv_if.sv
// Request/response bundle of the pipelined divider.
//   master: front end / consumer side (drives operands and output_ready)
//   slave : the divider (drives input_ready, results and busy)
interface pipelined_divider_sv_if #(
    parameter int unsigned dividend_width = 32,
    parameter int unsigned divisor_width  = 24,
    parameter int unsigned tag_width      = 6
);
    logic                      input_valid;
    logic                      input_ready;
    logic [tag_width-1:0]      input_tag;
    logic                      input_signed;
    logic [dividend_width-1:0] dividend;
    logic [divisor_width-1:0]  divisor;
    logic                      output_valid;
    logic                      output_ready;
    logic [tag_width-1:0]      output_tag;
    logic [dividend_width-1:0] quotient;
    logic [dividend_width-1:0] remainder;
    logic                      div_by_zero;
    logic                      busy;

    modport master (
        output input_valid, input_tag, input_signed, dividend, divisor, output_ready,
        input  input_ready, output_valid, output_tag, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  input_valid, input_tag, input_signed, dividend, divisor, output_ready,
        output input_ready, output_valid, output_tag, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/divider_stage.sv
// One iteration stage of the divider: resolves bits_per_stage quotient bits by
// restoring subtraction of the divisor magnitude from the partial remainder.
// Ports:
//   clock, reset      clock and asynchronous active-high reset (control state only)
//   enable_i          advance the stage (pipeline not stalled)
//   side_i/side_o     control sideband, tag_i/tag_o transaction tag
//   rem_i/rem_o       partial remainder
//   quo_i/quo_o       shift register: unconsumed dividend bits on top, quotient bits below
//   div_i/div_o       divisor magnitude
module divider_stage
    import pipelined_divider_pkg::*;
#(
    parameter int unsigned dividend_width = 32,
    parameter int unsigned divisor_width  = 24,
    parameter int unsigned tag_width      = 6,
    parameter int unsigned bits_per_stage = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable_i,
    input  side_flags_t               side_i,
    input  logic [tag_width-1:0]      tag_i,
    input  logic [dividend_width-1:0] rem_i,
    input  logic [dividend_width-1:0] quo_i,
    input  logic [divisor_width-1:0]  div_i,
    output side_flags_t               side_o,
    output logic [tag_width-1:0]      tag_o,
    output logic [dividend_width-1:0] rem_o,
    output logic [dividend_width-1:0] quo_o,
    output logic [divisor_width-1:0]  div_o
);
    localparam int unsigned W = dividend_width;

    side_flags_t          side_q;
    logic [tag_width-1:0] tag_q;
    logic [W-1:0]         rem_d, rem_q, quo_d, quo_q;
    logic [divisor_width-1:0] div_q;
    logic [W:0]           trial, div_ext;

    // Remainder is kept full width so a zero divisor simply shifts the whole
    // dividend magnitude into it, which is exactly the divide-by-zero remainder.
    always_comb begin
        div_ext = '0;
        div_ext[divisor_width-1:0] = div_i;
        rem_d = rem_i;
        quo_d = quo_i;
        trial = '0;
        for (int b = 0; b < int'(bits_per_stage); b++) begin
            trial = {rem_d, quo_d[W-1]};
            quo_d = {quo_d[W-2:0], 1'b0};
            if (trial >= div_ext) begin
                trial    = trial - div_ext;
                quo_d[0] = 1'b1;
            end
            rem_d = trial[W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            side_q <= '0;
            tag_q  <= '0;
        end else if (enable_i) begin
            side_q <= side_i;
            tag_q  <= tag_i;
        end
    end

    always_ff @(posedge clock) begin
        if (enable_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_i;
        end
    end

    assign side_o = side_q;
    assign tag_o  = tag_q;
    assign rem_o  = rem_q;
    assign quo_o  = quo_q;
    assign div_o  = div_q;
endmodule

// File: rtl/pipelined_divider_sv.sv
// Pipelined tagged integer divider, one transaction per cycle, in-order results.
// Pipeline: capture (sign/abs, zero and overflow detect) -> N iteration stages
// -> fixup (sign restore, special results) into the output registers.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   bus (slave)    input_valid/input_ready/input_tag/input_signed/dividend/divisor,
//                  output_valid/output_ready/output_tag/quotient/remainder/
//                  div_by_zero, busy
// The interface instance must use the same width parameters as this module.
module pipelined_divider_sv
    import pipelined_divider_pkg::*;
#(
    parameter int unsigned dividend_width = 32,
    parameter int unsigned divisor_width  = 24,
    parameter int unsigned tag_width      = 6,
    parameter int unsigned bits_per_stage = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    pipelined_divider_sv_if.slave bus
);
    localparam int unsigned W         = dividend_width;
    localparam int unsigned D         = divisor_width;
    localparam int unsigned NumStages = stage_count(dividend_width, bits_per_stage);
    localparam logic [W-1:0] MinNeg   = {1'b1, {(W-1){1'b0}}};

    logic stall, advance, accept;

    // A whole-pipeline stall keeps bubbles in place and results in order.
    assign stall           = bus.output_valid & ~bus.output_ready;
    assign advance         = ~stall;
    assign accept          = bus.input_valid & advance;
    assign bus.input_ready = advance;

    // Capture stage
    side_flags_t          cap_flags_d;
    logic [W-1:0]         dvd_abs;
    logic [D-1:0]         dvs_abs;

    side_flags_t          side [NumStages+1];
    logic [tag_width-1:0] tag  [NumStages+1];
    logic [W-1:0]         rem  [NumStages+1];
    logic [W-1:0]         quo  [NumStages+1];
    logic [D-1:0]         div  [NumStages+1];

    always_comb begin
        cap_flags_d.valid        = bus.input_valid;
        cap_flags_d.signed_op    = bus.input_signed;
        cap_flags_d.dividend_neg = bus.input_signed & bus.dividend[W-1];
        cap_flags_d.divisor_neg  = bus.input_signed & bus.divisor[D-1];
        cap_flags_d.dbz          = (bus.divisor == '0);
        cap_flags_d.overflow     = bus.input_signed & (bus.dividend == MinNeg) & (&bus.divisor);
        dvd_abs = cap_flags_d.dividend_neg ? -bus.dividend : bus.dividend;
        // Magnitude of the most negative divisor still fits D unsigned bits.
        dvs_abs = cap_flags_d.divisor_neg ? -bus.divisor : bus.divisor;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            side[0] <= '0;
            tag[0]  <= '0;
        end else if (advance) begin
            side[0] <= cap_flags_d;
            tag[0]  <= bus.input_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            quo[0] <= dvd_abs;
            div[0] <= dvs_abs;
        end
    end

    assign rem[0] = '0;

    for (genvar s = 0; s < NumStages; s++) begin : g_stage
        divider_stage #(
            .dividend_width (dividend_width),
            .divisor_width  (divisor_width),
            .tag_width      (tag_width),
            .bits_per_stage (bits_per_stage)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .enable_i (advance),
            .side_i   (side[s]),
            .tag_i    (tag[s]),
            .rem_i    (rem[s]),
            .quo_i    (quo[s]),
            .div_i    (div[s]),
            .side_o   (side[s+1]),
            .tag_o    (tag[s+1]),
            .rem_o    (rem[s+1]),
            .quo_o    (quo[s+1]),
            .div_o    (div[s+1])
        );
    end

    // Fixup stage
    side_flags_t  fix;
    logic [W-1:0] quo_fix, rem_fix;

    always_comb begin
        fix     = side[NumStages];
        quo_fix = (fix.signed_op & (fix.dividend_neg ^ fix.divisor_neg)) ? -quo[NumStages]
                                                                          : quo[NumStages];
        // Remainder follows the dividend sign; for a zero divisor this rebuilds the dividend.
        rem_fix = fix.dividend_neg ? -rem[NumStages] : rem[NumStages];
        if (fix.dbz) begin
            quo_fix = DbzQuotient[W-1:0];
        end else if (fix.overflow) begin
            quo_fix = MinNeg;
            rem_fix = '0;
        end
    end

    logic                 out_valid_q, dbz_q;
    logic [tag_width-1:0] out_tag_q;
    logic [W-1:0]         quotient_q, remainder_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= fix.valid;
            out_tag_q   <= tag[NumStages];
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
            dbz_q       <= fix.dbz;
        end
    end

    logic busy_c;

    always_comb begin
        busy_c = out_valid_q;
        for (int k = 0; k <= int'(NumStages); k++) begin
            busy_c = busy_c | side[k].valid;
        end
    end

    assign bus.output_valid = out_valid_q;
    assign bus.output_tag   = out_tag_q;
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;
    assign bus.div_by_zero  = dbz_q;
    assign bus.busy         = busy_c;
endmodule

// File: tb/tb_pipelined_divider_sv.sv
// Self-checking bench for pipelined_divider_sv (default parameters, 33-edge latency).
module tb_pipelined_divider_sv;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    pipelined_divider_sv_if bus ();

    pipelined_divider_sv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    int          checks   = 0;
    int          errors   = 0;
    int unsigned received = 0;
    exp_t        exp_q[$];
    exp_t        front;

    logic        prev_stall = 1'b0;
    logic        prev_valid, prev_dbz;
    logic [5:0]  prev_tag;
    logic [31:0] prev_q, prev_r;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endfunction

    // Reference result from plain integer arithmetic.
    function automatic exp_t model(input logic [5:0] tag, input logic sgn,
                                   input logic [31:0] a, input logic [23:0] b);
        exp_t e;
        int   sa, sb;
        e.tag = tag;
        e.dbz = 1'b0;
        if (b == 24'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (!sgn) begin
            e.q = a / {8'd0, b};
            e.r = a % {8'd0, b};
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == 32'sh8000_0000 && sb == -1) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = sa / sb;
                e.r = sa % sb;
            end
        end
        return e;
    endfunction

    // Scoreboard: record accepts, check every output transfer, handshake and hold.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (bus.input_valid && bus.input_ready)
                exp_q.push_back(model(bus.input_tag, bus.input_signed, bus.dividend,
                                      bus.divisor));
            check("input_ready", bus.input_ready, !(bus.output_valid && !bus.output_ready));
            if (prev_stall) begin
                check("held_valid", bus.output_valid, prev_valid);
                check("held_tag", bus.output_tag, prev_tag);
                check("held_q", bus.quotient, prev_q);
                check("held_r", bus.remainder, prev_r);
                check("held_dbz", bus.div_by_zero, prev_dbz);
            end
            if (bus.output_valid && bus.output_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_tag", bus.output_tag, 64'hDEAD);
                end else begin
                    front = exp_q.pop_front();
                    check("sb_tag", bus.output_tag, front.tag);
                    check("sb_q", bus.quotient, front.q);
                    check("sb_r", bus.remainder, front.r);
                    check("sb_dbz", bus.div_by_zero, front.dbz);
                end
                received++;
            end
            prev_stall = bus.output_valid && !bus.output_ready;
            prev_valid = bus.output_valid;
            prev_tag   = bus.output_tag;
            prev_q     = bus.quotient;
            prev_r     = bus.remainder;
            prev_dbz   = bus.div_by_zero;
        end
    end

    // One isolated transaction with literal expectations and a latency check.
    task automatic run_single(input string name, input logic sgn, input logic [31:0] a,
                              input logic [23:0] b, input logic [5:0] tag,
                              input logic [31:0] eq, input logic [31:0] er,
                              input logic edbz);
        exp_t m;
        int   edges;
        m = model(tag, sgn, a, b);
        check({name, "_model_q"}, m.q, eq);
        check({name, "_model_r"}, m.r, er);
        @(posedge clock);
        #1;
        bus.input_valid  = 1'b1;
        bus.input_signed = sgn;
        bus.dividend     = a;
        bus.divisor      = b;
        bus.input_tag    = tag;
        @(posedge clock);
        #1;
        bus.input_valid = 1'b0;
        edges = 0;
        while (!bus.output_valid && edges < 60) begin
            @(posedge clock);
            #1;
            edges++;
        end
        check({name, "_latency"}, edges, 33);
        check({name, "_valid"}, bus.output_valid, 1);
        check({name, "_tag"}, bus.output_tag, tag);
        check({name, "_q"}, bus.quotient, eq);
        check({name, "_r"}, bus.remainder, er);
        check({name, "_dbz"}, bus.div_by_zero, edbz);
    endtask

    // Back-to-back random stream; retries while input_ready is low.
    task automatic stream(input int first_tag, input int count);
        int i = 0;
        int guard = 0;
        int sel;
        logic rdy;
        while (i < count && guard < 2000) begin
            bus.input_valid  = 1'b1;
            bus.input_tag    = 6'(first_tag + i);
            bus.input_signed = 1'($urandom);
            bus.dividend     = $urandom;
            bus.divisor      = 24'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) bus.divisor = 24'd0;
            else if (sel < 3) bus.divisor = 24'($urandom_range(1, 15));
            else if (sel == 3 && bus.input_signed) begin
                bus.dividend = 32'h8000_0000;
                bus.divisor  = 24'hFF_FFFF;
            end
            @(negedge clock);
            rdy = bus.input_ready;
            @(posedge clock);
            #1;
            if (rdy) i++;
            guard++;
        end
        bus.input_valid = 1'b0;
        check("stream_accepted", i, count);
    endtask

    task automatic ready_ctl();
        int g = 0;
        while (!bus.output_valid && g < 200) begin
            @(posedge clock);
            #1;
            g++;
        end
        bus.output_ready = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        g = 0;
        while (received < 40 && g < 500) begin
            bus.output_ready = ~bus.output_ready;
            @(posedge clock);
            #1;
            g++;
        end
        bus.output_ready = 1'b1;
    endtask

    initial begin
        int g;
        bus.input_valid  = 1'b0;
        bus.input_tag    = '0;
        bus.input_signed = 1'b0;
        bus.dividend     = '0;
        bus.divisor      = '0;
        bus.output_ready = 1'b1;

        #1 reset = 1'b1;
        #2;
        check("rst_output_valid", bus.output_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_input_ready", bus.input_ready, 1);
        check("rst_tag", bus.output_tag, 0);
        check("rst_q", bus.quotient, 0);
        check("rst_r", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        run_single("u_100_7", 1'b0, 32'd100, 24'd7, 6'd5, 32'd14, 32'd2, 1'b0);
        run_single("s_m7_2", 1'b1, 32'hFFFF_FFF9, 24'd2, 6'd1, 32'hFFFF_FFFD,
                   32'hFFFF_FFFF, 1'b0);
        run_single("s_7_m2", 1'b1, 32'd7, 24'hFF_FFFE, 6'd2, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_single("u_dbz", 1'b0, 32'd1234, 24'd0, 6'd3, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        run_single("s_dbz", 1'b1, 32'hFFFF_FFFB, 24'd0, 6'd4, 32'hFFFF_FFFF,
                   32'hFFFF_FFFB, 1'b1);
        run_single("s_ovf", 1'b1, 32'h8000_0000, 24'hFF_FFFF, 6'd6, 32'h8000_0000, 32'd0,
                   1'b0);
        run_single("u_max", 1'b0, 32'hFFFF_FFFF, 24'hFF_FFFF, 6'd9, 32'h100, 32'hFF, 1'b0);

        // Backpressure
        @(posedge clock);
        #1;
        received = 0;
        fork
            stream(0, 40);
            ready_ctl();
        join
        check("bp_received", received, 40);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with transactions in flight and a stalled result at the output
        @(posedge clock);
        #1;
        bus.output_ready = 1'b0;
        stream(40, 20);
        g = 0;
        while (!bus.output_valid && g < 100) begin
            @(posedge clock);
            #1;
            g++;
        end
        check("pre_rst_valid", bus.output_valid, 1);
        check("pre_rst_busy", bus.busy, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", bus.output_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_input_ready", bus.input_ready, 1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        bus.output_ready = 1'b1;
        run_single("fresh_100_7", 1'b0, 32'd100, 24'd7, 6'd7, 32'd14, 32'd2, 1'b0);
        repeat (60) @(posedge clock);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_valid", bus.output_valid, 0);
        check("final_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_divider_sv.md
Name: pipelined_divider_sv

Overview:
Second-generation pipelined integer divider.
- Accepts one tagged division per cycle and returns quotient, remainder and tag in order.
- Extends the current divider with per-transaction signed/unsigned mode, a configurable number of quotient bits per stage, defined divide-by-zero and overflow results, and a ready/valid backpressure handshake.
- Sits between the tag-issuing front end and the result scoreboard.

Parameters:
- dividend_width, 32, width of dividend, quotient and remainder.
- divisor_width, 24, width of divisor. Must be <= dividend_width.
- tag_width, 6, width of the opaque tag carried alongside each transaction.
- bits_per_stage, 1, quotient bits resolved per iteration stage. Must be 1, 2 or 4 and must divide dividend_width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- input_valid  in  1  a transaction is offered.
- input_ready  out  1  the divider can accept a transaction this cycle.
- input_tag  in  tag_width  tag returned unchanged with the result.
- input_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- dividend  in  dividend_width  dividend.
- divisor  in  divisor_width  divisor.
- output_valid  out  1  a result is presented.
- output_ready  in  1  the consumer takes the result this cycle.
- output_tag  out  tag_width  tag of the presented result.
- quotient  out  dividend_width  quotient.
- remainder  out  dividend_width  remainder, sign-extended.
- div_by_zero  out  1  the divisor of this result was zero.
- busy  out  1  at least one pipeline stage holds a valid transaction.

Behaviour:
- Stage count: N = dividend_width / bits_per_stage.
- Pipeline layout: capture stage (operand sign/abs, zero detect), N iteration stages, fixup stage (sign restore). Each stage has its own valid bit.
- Transfers: accept = input_valid & input_ready; output transfer = output_valid & output_ready.
- Latency: a result accepted on edge E0 presents output_valid after edge E0+N+1, provided no stall occurs.
- Stall: stall = output_valid & ~output_ready.
  - When stall is high, every stage, including output registers, holds its value.
  - input_ready = ~stall (combinational).
  - Bubbles are not compressed.
- Throughput: one transaction per cycle when not stalled. Ordering is strictly preserved and tags are never reordered or dropped.
- Unsigned mode: quotient = dividend / divisor and remainder = dividend % divisor, both zero-extended.
- Signed mode: the divisor is sign-extended to dividend_width. The quotient truncates toward zero. The remainder takes the sign of the dividend, or is 0.
- Divide by zero, either mode: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Signed overflow (dividend = min negative, divisor = -1): quotient = min negative, remainder = 0, div_by_zero = 0.
- Reset values, applied immediately on reset assertion:
  - all stage valid bits 0.
  - output_valid, output_tag, quotient, remainder, div_by_zero, busy = 0.
  - input_ready = 1.
  - Iteration datapath registers need not be reset.
- Reset mid-operation: all in-flight transactions are discarded. None appears at the output after reset is released.
- Input sampling: input signals are sampled only on accept. Values while input_ready = 0 are ignored.
- Held outputs: the output values stay stable while stalled.

Decomposition:
- Package pipelined_divider_pkg:
  - stage-count function.
  - divide-by-zero quotient constant.
  - sideband struct {valid, tag, signed flag, dividend-negative, divisor-negative, dbz, overflow}, parametrised by tag_width.
- Sub-module divider_stage: one iteration stage resolving bits_per_stage quotient bits by restoring subtraction. It takes partial remainder, divisor magnitude and sideband, plus an enable (= ~stall).
- The top level instantiates N copies of divider_stage with generate, plus the capture and fixup logic.

Test Plan:
Defaults throughout; N = 32; no-stall latency is 33 edges.
1. Unsigned: 100 / 7, tag 5 -> 33 edges later output_valid = 1, quotient = 14, remainder = 2, output_tag = 5, div_by_zero = 0.
2. Signed:
   - -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
   - 7 / -2 (divisor 0xFFFFFE) -> quotient 0xFFFFFFFD, remainder 1.
3. Divide by zero:
   - unsigned 1234 / 0 -> quotient 0xFFFFFFFF, remainder 1234, div_by_zero = 1.
   - signed -5 / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB, div_by_zero = 1.
4. Overflow: signed 0x80000000 / 0xFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero = 0.
5. Backpressure:
   - Stimulus: stream tags 0..39 back-to-back with random operands; drop output_ready for 10 cycles after the first result, then toggle it every cycle.
   - Required: all 40 results emerge in tag order and match the model.
   - Required: input_ready is low exactly when output_valid & ~output_ready.
   - Required: held outputs stay stable during each stall.
6. Reset mid-operation:
   - Stimulus: with 20 transactions in flight, pulse reset between clock edges.
   - Required: output_valid and busy fall immediately.
   - Required: after release, no stale tag ever appears, and a fresh 100 / 7 returns 14 after 33 edges.
